// File: rtl/uart_word_rx_assembler_if.sv
// Byte-in / word-out bundle between the UART receiver, the controller and the memory port.
// master drives the control and rx-byte side; slave is the assembler.
interface uart_word_rx_assembler_if #(
  parameter int MEM_WORD_LENGTH = 12,
  parameter int MEM_ADDR_LENGTH = 12
);
  logic                       start;
  logic [MEM_ADDR_LENGTH-1:0] start_addr;
  logic [MEM_ADDR_LENGTH-1:0] end_addr;
  logic                       rx_byte_valid;
  logic [7:0]                 rx_byte;
  logic                       mem_wr_en;
  logic [MEM_ADDR_LENGTH-1:0] mem_address;
  logic [MEM_WORD_LENGTH-1:0] data_to_mem;
  logic                       busy;
  logic                       mem_received;
  logic                       timeout_err;

  modport master (
    output start, start_addr, end_addr, rx_byte_valid, rx_byte,
    input  mem_wr_en, mem_address, data_to_mem, busy, mem_received, timeout_err
  );

  modport slave (
    input  start, start_addr, end_addr, rx_byte_valid, rx_byte,
    output mem_wr_en, mem_address, data_to_mem, busy, mem_received, timeout_err
  );
endinterface

// File: rtl/uart_word_rx_assembler.sv
// Assembles LSB-first UART bytes into memory words and writes them to start_addr..end_addr.
// state     | meaning
// IDLE      | not armed, rx bytes ignored
// WAIT_BYTE | collecting bytes of the current word, partial-word timer running
// WRITE     | one-cycle memory write of the assembled word
module uart_word_rx_assembler #(
  parameter int MEM_WORD_LENGTH = 12,
  parameter int MEM_ADDR_LENGTH = 12,
  parameter int TIMEOUT_CYCLES  = 100000
) (
  input logic clk,
  input logic rst,
  uart_word_rx_assembler_if.slave bus
);
  localparam int NBYTES = (MEM_WORD_LENGTH + 7) / 8;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int TMR_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);
  localparam logic [TMR_W-1:0] TMR_LOAD  = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT_BYTE, WRITE} state_t;

  state_t                     state, nextState;
  logic [MEM_ADDR_LENGTH-1:0] addr, endAddr;
  logic [CNT_W-1:0]           byteCnt, byteIdx;
  logic [TMR_W-1:0]           timer;
  logic [MEM_WORD_LENGTH-1:0] asmReg, asmNext;
  logic                       lastByte, lastWord, timeoutHit;

  assign lastByte   = (byteCnt == LAST_BYTE);
  assign lastWord   = (addr == endAddr);
  // Down-counter reloaded on every byte; terminal count with no byte drops the partial word.
  assign timeoutHit = (state == WAIT_BYTE) && (byteCnt != '0) && (timer == '0) && !bus.rx_byte_valid;
  // A byte arriving during WRITE is byte 0 of the next word.
  assign byteIdx    = (state == WRITE) ? '0 : byteCnt;

  always_comb begin
    asmNext = asmReg;
    for (int j = 0; j < MEM_WORD_LENGTH; j++) begin
      if (byteIdx == CNT_W'(j / 8)) asmNext[j] = bus.rx_byte[j % 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:      if (bus.start) nextState = WAIT_BYTE;
      WAIT_BYTE: if (bus.rx_byte_valid && lastByte) nextState = WRITE;
      WRITE:     nextState = lastWord ? IDLE : WAIT_BYTE;
      default:   nextState = IDLE;
    endcase
  end

  always_comb begin
    bus.busy         = (state != IDLE);
    bus.mem_wr_en    = (state == WRITE);
    bus.mem_received = (state == WRITE) && lastWord;
    bus.timeout_err  = timeoutHit;
    bus.mem_address  = addr;
    bus.data_to_mem  = asmReg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr    <= '0;
      endAddr <= '0;
      byteCnt <= '0;
      timer   <= '0;
      asmReg  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            addr    <= bus.start_addr;
            endAddr <= bus.end_addr;
            byteCnt <= '0;
            timer   <= '0;
          end
        end
        WAIT_BYTE: begin
          if (bus.rx_byte_valid) begin
            asmReg <= asmNext;
            timer  <= TMR_LOAD;
            if (!lastByte) byteCnt <= byteCnt + 1'b1;
          end else if (byteCnt != '0) begin
            if (timer == '0) byteCnt <= '0;
            else             timer   <= timer - 1'b1;
          end
        end
        WRITE: begin
          if (!lastWord) begin
            addr <= addr + 1'b1;
            if (bus.rx_byte_valid) begin
              asmReg  <= asmNext;
              byteCnt <= CNT_W'(1);
              timer   <= TMR_LOAD;
            end else begin
              byteCnt <= '0;
            end
          end
        end
        default: byteCnt <= '0;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_word_rx_assembler.sv
// Bench for uart_word_rx_assembler: table-driven transfers plus hand-written corner sequences,
// with expected writes queued on the final byte of each word and checked when the write appears.
module tb_uart_word_rx_assembler;
  localparam int TC = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_word_rx_assembler_if #(.MEM_WORD_LENGTH(12), .MEM_ADDR_LENGTH(12)) bus ();

  uart_word_rx_assembler #(
    .MEM_WORD_LENGTH(12),
    .MEM_ADDR_LENGTH(12),
    .TIMEOUT_CYCLES (TC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [11:0] addr;
    logic [11:0] data;
    logic        last;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [11:0]       sa;
    logic [11:0]       ea;
    int                nWords;
    logic [5:0][7:0]   bytes;
    logic [2:0][11:0]  data;
    logic [2:0][11:0]  addr;
  } vec_t;

  exp_t expQ[$];
  vec_t vec[4];
  int   checks = 0;
  int   passes = 0;
  int   toCnt = 0;
  int   cycCnt = 0;
  int   toBase;

  always @(posedge clk) cycCnt <= cycCnt + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // Outputs are sampled mid-cycle; inputs change 1 time unit after the rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (bus.timeout_err === 1'b1) toCnt++;
    if (bus.mem_wr_en === 1'b1) begin
      check("write_expected", 32'(expQ.size() != 0), 32'd1);
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        check("mem_address", 32'(bus.mem_address), 32'(e.addr));
        check("data_to_mem", 32'(bus.data_to_mem), 32'(e.data));
        check("mem_received", 32'(bus.mem_received), 32'(e.last));
        check("write_latency_cycle", cycCnt, e.cyc);
      end
    end else if (bus.mem_received !== 1'b0 && !rst) begin
      check("mem_received_without_write", 32'(bus.mem_received), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic startXfer(input logic [11:0] sa, input logic [11:0] ea);
    bus.start = 1'b1;
    bus.start_addr = sa;
    bus.end_addr = ea;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b);
    bus.rx_byte_valid = 1'b1;
    bus.rx_byte = b;
    tick();
    bus.rx_byte_valid = 1'b0;
  endtask

  task automatic expectWrite(input logic [11:0] a, input logic [11:0] d, input logic last);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.last = last;
    e.cyc  = cycCnt + 1;
    expQ.push_back(e);
  endtask

  task automatic checkDone(input string name);
    check({name, "_busy_low"}, 32'(bus.busy), 32'd0);
    check({name, "_all_writes_seen"}, expQ.size(), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0] = '{12'h010, 12'h012, 3, {8'h08, 8'h00, 8'h0B, 8'hCD, 8'hF2, 8'h34},
               {12'h800, 12'hBCD, 12'h234}, {12'h012, 12'h011, 12'h010}};
    vec[1] = '{12'hFFF, 12'h001, 3, {8'hF3, 8'hC3, 8'h02, 8'hB2, 8'h01, 8'hA1},
               {12'h3C3, 12'h2B2, 12'h1A1}, {12'h001, 12'h000, 12'hFFF}};
    vec[2] = '{12'h7AB, 12'h7AB, 1, {8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF},
               {12'h000, 12'h000, 12'hFFF}, {12'h000, 12'h000, 12'h7AB}};
    vec[3] = '{12'h100, 12'h102, 3, {8'hA5, 8'h5A, 8'h0F, 8'hFF, 8'h00, 8'h00},
               {12'h55A, 12'hFFF, 12'h000}, {12'h102, 12'h101, 12'h100}};

    bus.start = 1'b0;
    bus.start_addr = '0;
    bus.end_addr = '0;
    bus.rx_byte_valid = 1'b0;
    bus.rx_byte = '0;
    idle(2);
    rst = 1'b0;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_mem_wr_en", 32'(bus.mem_wr_en), 32'd0);
    check("reset_mem_address", 32'(bus.mem_address), 32'd0);
    check("reset_data_to_mem", 32'(bus.data_to_mem), 32'd0);
    check("reset_mem_received", 32'(bus.mem_received), 32'd0);
    check("reset_timeout_err", 32'(bus.timeout_err), 32'd0);

    // Bytes while idle must not write or arm anything.
    sendByte(8'hAA);
    sendByte(8'h55);
    idle(2);
    checkDone("idle_bytes");

    for (int v = 0; v < 4; v++) begin
      startXfer(vec[v].sa, vec[v].ea);
      check("busy_after_start", 32'(bus.busy), 32'd1);
      for (int w = 0; w < vec[v].nWords; w++) begin
        for (int b = 0; b < 2; b++) begin
          if (b == 1) expectWrite(vec[v].addr[w], vec[v].data[w], w == vec[v].nWords - 1);
          sendByte(vec[v].bytes[2 * w + b]);
          idle($urandom_range(0, 2));
        end
      end
      idle(3);
      checkDone("table_xfer");
    end

    // Partial word times out, then the same address is written by a fresh word.
    toBase = toCnt;
    startXfer(12'h020, 12'h020);
    sendByte(8'h55);
    idle(TC - 2);
    check("timeout_not_early", toCnt, toBase);
    idle(2);
    check("timeout_pulse", toCnt, toBase + 1);
    check("busy_after_timeout", 32'(bus.busy), 32'd1);
    sendByte(8'h11);
    expectWrite(12'h020, 12'h211, 1'b1);
    sendByte(8'h02);
    idle(3);
    checkDone("timeout_xfer");

    // Byte arriving in the very cycle the timer expires completes the word.
    toBase = toCnt;
    startXfer(12'h030, 12'h030);
    sendByte(8'h77);
    idle(TC - 1);
    expectWrite(12'h030, 12'h477, 1'b1);
    sendByte(8'h04);
    idle(3);
    check("byte_beats_timeout", toCnt, toBase);
    checkDone("byte_wins_xfer");

    // Byte in WRITE of word 0 becomes byte 0 of word 1; byte in final WRITE is dropped.
    toBase = toCnt;
    startXfer(12'h000, 12'h001);
    sendByte(8'hA1);
    expectWrite(12'h000, 12'hCA1, 1'b0);
    sendByte(8'h0C);
    sendByte(8'hE5);
    expectWrite(12'h001, 12'h7E5, 1'b1);
    sendByte(8'h07);
    sendByte(8'h99);
    idle(TC + 3);
    check("dropped_byte_no_timeout", toCnt, toBase);
    checkDone("write_cycle_byte");

    // Reset mid-word clears everything; later bytes do nothing.
    toBase = toCnt;
    startXfer(12'h040, 12'h041);
    sendByte(8'h12);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_mem_wr_en", 32'(bus.mem_wr_en), 32'd0);
    check("midrst_mem_address", 32'(bus.mem_address), 32'd0);
    check("midrst_data_to_mem", 32'(bus.data_to_mem), 32'd0);
    check("midrst_mem_received", 32'(bus.mem_received), 32'd0);
    sendByte(8'h34);
    sendByte(8'h56);
    idle(TC + 3);
    check("midrst_no_timeout", toCnt, toBase);
    checkDone("midrst");

    // A second start while busy is ignored; the original range and byte count stand.
    startXfer(12'h050, 12'h051);
    sendByte(8'h21);
    startXfer(12'h300, 12'h300);
    expectWrite(12'h050, 12'h321, 1'b0);
    sendByte(8'h03);
    sendByte(8'h44);
    expectWrite(12'h051, 12'h544, 1'b1);
    sendByte(8'h05);
    idle(3);
    checkDone("restart_ignored");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
